// File: rtl/pipe_if_id_queue_pkg.sv
// Shared widths and constants for the IF/ID decoupling queue.
//   MemAddrBus / InstBus : default pc and instruction widths
//   QueueDepth           : default number of storage entries
//   BubbleInst           : instruction word presented to ID when no work is available
//   cnt_width()          : width needed to count 0..depth inclusive
package pipe_if_id_queue_pkg;

  localparam int unsigned MemAddrBus = 32;
  localparam int unsigned InstBus    = 32;
  localparam int unsigned QueueDepth = 4;

  localparam logic [InstBus-1:0] BubbleInst = '0;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_fifo.sv
// In-order storage queue with a synchronous clear.
//   clock, reset : clock and synchronous active-high reset
//   clear_i      : drop all entries (same effect as reset on pointers and count)
//   push_i       : write wdata_i at the tail (caller guarantees not full)
//   pop_i        : advance the head (caller guarantees not empty)
//   rdata_o      : current head entry
//   count_o      : number of held entries, 0..Depth
//   empty_o/full_o : occupancy flags
module pipe_fifo
  import pipe_if_id_queue_pkg::*;
#(
  parameter int unsigned Width    = 64,
  parameter int unsigned Depth    = QueueDepth,
  localparam int unsigned PtrWidth = $clog2(Depth),
  localparam int unsigned CntWidth = cnt_width(Depth)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear_i,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [Width-1:0]    wdata_i,
  output logic [Width-1:0]    rdata_o,
  output logic [CntWidth-1:0] count_o,
  output logic                empty_o,
  output logic                full_o
);

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;

  // Depth is a power of two, so pointers wrap naturally; count separates full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrWidth'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CntWidth'(1);
        2'b01:   count_d = count_q - CntWidth'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observable through count/pointers.
  always_ff @(posedge clock) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntWidth'(Depth));

endmodule

// File: rtl/pipe_if_id_queue.sv
// IF/ID decoupling queue: DEPTH-entry FIFO of (pc, inst) plus a registered output slot for ID.
//   clock, reset        : clock and synchronous active-high reset
//   flush               : redirect, discards everything held and anything offered this cycle
//   in_valid/in_pc/in_inst : fetched instruction from IF
//   in_ready            : queue storage not full
//   id_stall            : ID cannot consume the output slot this cycle
//   pc_o/inst_o/valid_o : registered output slot (zero bubble when empty)
//   count_o             : storage occupancy, output slot excluded
module pipe_if_id_queue
  import pipe_if_id_queue_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MemAddrBus,
  parameter int unsigned INST_WIDTH = InstBus,
  parameter int unsigned DEPTH      = QueueDepth,
  localparam int unsigned CNT_WIDTH = cnt_width(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  input  logic [INST_WIDTH-1:0] in_inst,
  output logic                  in_ready,
  input  logic                  id_stall,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic                  valid_o,
  output logic [CNT_WIDTH-1:0]  count_o
);

  localparam int unsigned EntryWidth = ADDR_WIDTH + INST_WIDTH;

  logic [EntryWidth-1:0] fifo_rdata;
  logic [CNT_WIDTH-1:0]  fifo_count;
  logic                  fifo_empty, fifo_full;
  logic                  acc, adv, do_pop, do_bypass, do_push;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  valid_q, valid_d;

  always_comb begin
    acc       = in_valid && !fifo_full;
    // A bubble in the slot can always be overwritten, even under stall.
    adv       = !id_stall || !valid_q;
    do_pop    = adv && !fifo_empty;
    do_bypass = adv && fifo_empty && acc;
    do_push   = acc && !do_bypass;

    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (flush) begin
      pc_d    = '0;
      inst_d  = INST_WIDTH'(BubbleInst);
      valid_d = 1'b0;
    end else if (adv) begin
      if (!fifo_empty) begin
        {pc_d, inst_d} = fifo_rdata;
        valid_d        = 1'b1;
      end else if (acc) begin
        pc_d    = in_pc;
        inst_d  = in_inst;
        valid_d = 1'b1;
      end else begin
        pc_d    = '0;
        inst_d  = INST_WIDTH'(BubbleInst);
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  // Clear dominates push/pop inside the FIFO, so a flush-cycle accept is dropped there.
  pipe_fifo #(
    .Width (EntryWidth),
    .Depth (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .clear_i (flush),
    .push_i  (do_push),
    .pop_i   (do_pop),
    .wdata_i ({in_pc, in_inst}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign in_ready = !fifo_full;
  assign pc_o     = pc_q;
  assign inst_o   = inst_q;
  assign valid_o  = valid_q;
  assign count_o  = fifo_count;

endmodule

// File: tb/tb_pipe_if_id_queue.sv
module tb_pipe_if_id_queue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        in_ready;
  logic        id_stall = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;
  logic [2:0]  count_o;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipe_if_id_queue #(
    .ADDR_WIDTH (32),
    .INST_WIDTH (32),
    .DEPTH      (DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_pc    (in_pc),
    .in_inst  (in_inst),
    .in_ready (in_ready),
    .id_stall (id_stall),
    .pc_o     (pc_o),
    .inst_o   (inst_o),
    .valid_o  (valid_o),
    .count_o  (count_o)
  );

  // Reference model: a plain queue for storage plus one output slot.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t      m_q[$];
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_inst = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    entry_t e;
    bit     acc, adv;
    if (reset || flush) begin
      m_q.delete();
      m_valid = 1'b0; m_pc = '0; m_inst = '0;
      return;
    end
    acc    = in_valid && (m_q.size() != DEPTH);
    adv    = !id_stall || !m_valid;
    e.pc   = in_pc;
    e.inst = in_inst;
    if (adv) begin
      if (m_q.size() > 0) begin
        entry_t h;
        h = m_q.pop_front();
        m_valid = 1'b1; m_pc = h.pc; m_inst = h.inst;
        if (acc) m_q.push_back(e);
      end else if (acc) begin
        m_valid = 1'b1; m_pc = in_pc; m_inst = in_inst;
      end else begin
        m_valid = 1'b0; m_pc = '0; m_inst = '0;
      end
    end else if (acc) begin
      m_q.push_back(e);
    end
  endtask

  task automatic compare_model();
    check("model_valid", {31'b0, valid_o}, {31'b0, m_valid});
    check("model_pc", pc_o, m_pc);
    check("model_inst", inst_o, m_inst);
    check("model_count", {29'b0, count_o}, m_q.size());
    check("model_ready", {31'b0, in_ready}, {31'b0, (m_q.size() != DEPTH)});
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    reset = 0; flush = 0; in_valid = 0; id_stall = 0; in_pc = '0; in_inst = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  typedef struct {
    logic        rst, fl, iv;
    logic [31:0] pc, inst;
    logic        stall;
    logic        e_valid;
    logic [31:0] e_pc, e_inst;
    int          e_count;
    logic        e_ready;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,   32'h0,        0, 1};
    vecs[1] = '{0, 0, 1, 32'h100, 32'h00500093, 0, 1, 32'h100, 32'h00500093, 0, 1};
    vecs[2] = '{0, 0, 1, 32'h104, 32'h11,       1, 1, 32'h100, 32'h00500093, 1, 1};
    vecs[3] = '{0, 0, 1, 32'h108, 32'h22,       1, 1, 32'h100, 32'h00500093, 2, 1};
    vecs[4] = '{0, 0, 0, 32'h0,   32'h0,        0, 1, 32'h104, 32'h11,       1, 1};
    vecs[5] = '{0, 1, 1, 32'h200, 32'h33,       0, 0, 32'h0,   32'h0,        0, 1};
    vecs[6] = '{0, 0, 1, 32'h300, 32'h44,       1, 1, 32'h300, 32'h44,       0, 1};
    vecs[7] = '{0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,   32'h0,        0, 1};

    // Table-driven vectors from reset.
    for (int i = 0; i < 8; i++) begin
      reset = vecs[i].rst; flush = vecs[i].fl; in_valid = vecs[i].iv;
      in_pc = vecs[i].pc; in_inst = vecs[i].inst; id_stall = vecs[i].stall;
      tick();
      check($sformatf("vec%0d_valid", i), {31'b0, valid_o}, {31'b0, vecs[i].e_valid});
      check($sformatf("vec%0d_pc", i), pc_o, vecs[i].e_pc);
      check($sformatf("vec%0d_inst", i), inst_o, vecs[i].e_inst);
      check($sformatf("vec%0d_count", i), {29'b0, count_o}, vecs[i].e_count);
      check($sformatf("vec%0d_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].e_ready});
    end

    // Stall fill: six back-to-back offers under stall, the sixth must be refused.
    do_reset();
    id_stall = 1; in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      in_pc = 32'h400 + 4 * i; in_inst = 32'h1000 + i;
      if (i == 5) check("stall_fill_ready_low", {31'b0, in_ready}, 32'h0);
      tick();
    end
    check("stall_fill_count", {29'b0, count_o}, 32'd4);
    check("stall_fill_head", pc_o, 32'h400);
    in_valid = 0; id_stall = 0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall_drain_pc%0d", k), pc_o, 32'h400 + 4 * k);
      check($sformatf("stall_drain_valid%0d", k), {31'b0, valid_o}, 32'h1);
      tick();
    end
    check("stall_drain_bubble", {31'b0, valid_o}, 32'h0);

    // Full storage with a pop: no pass-through, then wrap-around ordering.
    do_reset();
    id_stall = 1; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      in_pc = 32'h500 + 4 * i; in_inst = 32'h2000 + i;
      tick();
    end
    id_stall = 0; in_pc = 32'h600; in_inst = 32'h3000;
    check("full_ready_low", {31'b0, in_ready}, 32'h0);
    tick();
    check("full_pop_count", {29'b0, count_o}, 32'd3);
    check("full_pop_head", pc_o, 32'h504);
    for (int j = 0; j < 8; j++) begin
      in_pc = 32'h600 + 4 * j; in_inst = 32'h3000 + j;
      tick();
      check($sformatf("wrap_order%0d", j), pc_o,
            (j < 3) ? 32'h508 + 4 * j : 32'h600 + 4 * (j - 3));
    end
    in_valid = 0;
    repeat (6) tick();

    // Reset mid-operation with three stored entries.
    do_reset();
    id_stall = 1; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_pc = 32'h700 + 4 * i; in_inst = 32'h4000 + i;
      tick();
    end
    check("midreset_pre_count", {29'b0, count_o}, 32'd3);
    in_valid = 0; reset = 1;
    tick();
    reset = 0;
    check("midreset_count", {29'b0, count_o}, 32'd0);
    check("midreset_valid", {31'b0, valid_o}, 32'h0);
    check("midreset_inst", inst_o, 32'h0);
    check("midreset_ready", {31'b0, in_ready}, 32'h1);

    // Flush with a simultaneous push: the pushed entry must never surface.
    do_reset();
    id_stall = 1; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_pc = 32'h800 + 4 * i; in_inst = 32'h5000 + i;
      tick();
    end
    check("flush_pre_count", {29'b0, count_o}, 32'd2);
    flush = 1; in_pc = 32'h200; in_inst = 32'h6000;
    tick();
    flush = 0; in_valid = 0; id_stall = 0;
    check("flush_valid", {31'b0, valid_o}, 32'h0);
    check("flush_count", {29'b0, count_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("flush_no_200_%0d", i), {31'b0, (pc_o == 32'h200)}, 32'h0);
      tick();
    end

    // Randomized traffic against the model, with stall pressure varying per phase.
    do_reset();
    for (int ph = 0; ph < 8; ph++) begin
      int stall_pct;
      stall_pct = (ph % 4) * 30;
      for (int c = 0; c < 250; c++) begin
        reset    = ($urandom_range(0, 199) == 0);
        flush    = ($urandom_range(0, 29) == 0);
        in_valid = ($urandom_range(0, 99) < 75);
        id_stall = ($urandom_range(0, 99) < stall_pct);
        in_pc    = $urandom;
        in_inst  = $urandom;
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
